branch_predictor: RTL and testbench

//  Fetch-stage tournament branch predictor plus branch target buffer (BTB) for the pipelined RV32 core.

---
 rtl/branch_pred_pkg.sv | 30 +++
 rtl/bp_counter_table.sv | 45 ++++
 rtl/branch_predictor.sv | 153 +++++++++++++++
 tb/tb_branch_predictor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// Shared types, default table geometry and the 2-bit saturating counter rule
// for the tournament branch predictor.
package branch_pred_pkg;

   typedef logic [1:0] counter_t;

   localparam counter_t CNT_INIT = 2'b01;

   localparam int unsigned DEF_BTB_ENTRIES  = 128;
   localparam int unsigned DEF_LHT_ENTRIES  = 128;
   localparam int unsigned DEF_LHR_BITS     = 8;
   localparam int unsigned DEF_GHR_BITS     = 8;
   localparam int unsigned DEF_META_ENTRIES = 128;

   localparam int unsigned DEF_BTB_IDX_W  = $clog2(DEF_BTB_ENTRIES);
   localparam int unsigned DEF_LHT_IDX_W  = $clog2(DEF_LHT_ENTRIES);
   localparam int unsigned DEF_META_IDX_W = $clog2(DEF_META_ENTRIES);

   function automatic counter_t cnt_update(input counter_t cnt, input logic up);
      counter_t res;
      res = cnt;
      if (up && cnt != 2'b11) begin
         res = cnt + 2'b01;
      end else if (!up && cnt != 2'b00) begin
         res = cnt - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Array of 2-bit saturating counters: two async read ports, one synchronous
// train-up/down write port, synchronous reset of every entry to CNT_INIT.
module bp_counter_table
   import branch_pred_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_a,
   output counter_t         rd_cnt_a,
   input  logic [IDX_W-1:0] rd_idx_b,
   output counter_t         rd_cnt_b,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_up
);

   counter_t mem_q [DEPTH];
   counter_t mem_d [DEPTH];

   always_comb begin
      rd_cnt_a = mem_q[rd_idx_a];
      rd_cnt_b = mem_q[rd_idx_b];
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_idx] = cnt_update(mem_q[wr_idx], wr_up);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= CNT_INIT;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Tournament (local + gshare + per-PC chooser) direction predictor with a
// direct-mapped untagged BTB; predicts in IF, trains non-speculatively from EX.
module branch_predictor
   import branch_pred_pkg::*;
#(
   parameter int unsigned BTB_ENTRIES  = DEF_BTB_ENTRIES,
   parameter int unsigned LHT_ENTRIES  = DEF_LHT_ENTRIES,
   parameter int unsigned LHR_BITS     = DEF_LHR_BITS,
   parameter int unsigned GHR_BITS     = DEF_GHR_BITS,
   parameter int unsigned META_ENTRIES = DEF_META_ENTRIES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_if,
   input  logic        is_branch_if,
   output logic [31:0] predicted_pc,
   output logic        predict_taken,
   output logic        local_taken,
   output logic        global_taken,
   output logic        use_global,
   input  logic [31:0] pc_ex,
   input  logic        is_branch_ex,
   input  logic        br_en_ex,
   input  logic [31:0] branch_pc_ex
);

   localparam int unsigned BTB_IDX_W  = $clog2(BTB_ENTRIES);
   localparam int unsigned LHT_IDX_W  = $clog2(LHT_ENTRIES);
   localparam int unsigned META_IDX_W = $clog2(META_ENTRIES);

   logic [31:0]          btb_q [BTB_ENTRIES];
   logic [31:0]          btb_d [BTB_ENTRIES];
   logic [LHR_BITS-1:0]  lht_q [LHT_ENTRIES];
   logic [LHR_BITS-1:0]  lht_d [LHT_ENTRIES];
   logic [GHR_BITS-1:0]  ghr_q;
   logic [GHR_BITS-1:0]  ghr_d;

   logic [BTB_IDX_W-1:0]  btb_idx_if, btb_idx_ex;
   logic [LHT_IDX_W-1:0]  lht_idx_if, lht_idx_ex;
   logic [META_IDX_W-1:0] meta_idx_if, meta_idx_ex;
   logic [LHR_BITS-1:0]   lhr_if, lhr_ex;
   logic [GHR_BITS-1:0]   gidx_if, gidx_ex;

   counter_t lcnt_if, lcnt_ex, gcnt_if, gcnt_ex, mcnt_if, mcnt_ex;
   logic     local_ex, global_ex;
   logic     meta_up, meta_we, meta_sat;
   logic     unused_pc;

   always_comb begin
      btb_idx_if  = pc_if[BTB_IDX_W+1:2];
      btb_idx_ex  = pc_ex[BTB_IDX_W+1:2];
      lht_idx_if  = pc_if[LHT_IDX_W+1:2];
      lht_idx_ex  = pc_ex[LHT_IDX_W+1:2];
      meta_idx_if = pc_if[META_IDX_W+1:2];
      meta_idx_ex = pc_ex[META_IDX_W+1:2];
      lhr_if      = lht_q[lht_idx_if];
      lhr_ex      = lht_q[lht_idx_ex];
      gidx_if     = pc_if[GHR_BITS+1:2] ^ ghr_q;
      gidx_ex     = pc_ex[GHR_BITS+1:2] ^ ghr_q;
   end

   // Chooser only moves when the two components disagree; a saturated
   // counter would not change anyway, so its write is skipped.
   always_comb begin
      local_ex  = lcnt_ex[1];
      global_ex = gcnt_ex[1];
      meta_up   = (global_ex == br_en_ex);
      meta_sat  = meta_up ? (mcnt_ex == 2'b11) : (mcnt_ex == 2'b00);
      meta_we   = is_branch_ex && (local_ex != global_ex) && !meta_sat;
   end

   always_comb begin
      predicted_pc  = btb_q[btb_idx_if];
      local_taken   = lcnt_if[1];
      global_taken  = gcnt_if[1];
      use_global    = mcnt_if[1];
      predict_taken = is_branch_if && (use_global ? global_taken : local_taken);
      unused_pc     = ^{pc_if, pc_ex};
   end

   always_comb begin
      btb_d = btb_q;
      lht_d = lht_q;
      ghr_d = ghr_q;
      if (is_branch_ex) begin
         btb_d[btb_idx_ex] = branch_pc_ex;
         lht_d[lht_idx_ex] = {lhr_ex[LHR_BITS-2:0], br_en_ex};
         ghr_d             = {ghr_q[GHR_BITS-2:0], br_en_ex};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            btb_q[i] <= '0;
         end
         for (int unsigned i = 0; i < LHT_ENTRIES; i++) begin
            lht_q[i] <= '0;
         end
         ghr_q <= '0;
      end else begin
         btb_q <= btb_d;
         lht_q <= lht_d;
         ghr_q <= ghr_d;
      end
   end

   bp_counter_table #(
      .DEPTH (2**LHR_BITS),
      .IDX_W (LHR_BITS)
   ) u_lpht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx_a (lhr_if),
      .rd_cnt_a (lcnt_if),
      .rd_idx_b (lhr_ex),
      .rd_cnt_b (lcnt_ex),
      .wr_en    (is_branch_ex),
      .wr_idx   (lhr_ex),
      .wr_up    (br_en_ex)
   );

   bp_counter_table #(
      .DEPTH (2**GHR_BITS),
      .IDX_W (GHR_BITS)
   ) u_gpht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx_a (gidx_if),
      .rd_cnt_a (gcnt_if),
      .rd_idx_b (gidx_ex),
      .rd_cnt_b (gcnt_ex),
      .wr_en    (is_branch_ex),
      .wr_idx   (gidx_ex),
      .wr_up    (br_en_ex)
   );

   bp_counter_table #(
      .DEPTH (META_ENTRIES),
      .IDX_W (META_IDX_W)
   ) u_meta (
      .clk      (clk),
      .rst      (rst),
      .rd_idx_a (meta_idx_if),
      .rd_cnt_a (mcnt_if),
      .rd_idx_b (meta_idx_ex),
      .rd_cnt_b (mcnt_ex),
      .wr_en    (meta_we),
      .wr_idx   (meta_idx_ex),
      .wr_up    (meta_up)
   );

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against a table-level
// reference model of the tournament predictor and BTB.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] pc_if;
   logic        is_branch_if;
   logic [31:0] predicted_pc;
   logic        predict_taken;
   logic        local_taken;
   logic        global_taken;
   logic        use_global;
   logic [31:0] pc_ex;
   logic        is_branch_ex;
   logic        br_en_ex;
   logic [31:0] branch_pc_ex;

   int checks   = 0;
   int failures = 0;

   int unsigned m_btb  [128];
   int unsigned m_lht  [128];
   int unsigned m_lpht [256];
   int unsigned m_gpht [256];
   int unsigned m_meta [128];
   int unsigned m_ghr;

   branch_predictor #(
      .BTB_ENTRIES  (128),
      .LHT_ENTRIES  (128),
      .LHR_BITS     (8),
      .GHR_BITS     (8),
      .META_ENTRIES (128)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_if         (pc_if),
      .is_branch_if  (is_branch_if),
      .predicted_pc  (predicted_pc),
      .predict_taken (predict_taken),
      .local_taken   (local_taken),
      .global_taken  (global_taken),
      .use_global    (use_global),
      .pc_ex         (pc_ex),
      .is_branch_ex  (is_branch_ex),
      .br_en_ex      (br_en_ex),
      .branch_pc_ex  (branch_pc_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=0x%08h expected=0x%08h", name, $time, act, exp);
      end
   endtask

   function automatic int unsigned sat(input int unsigned c, input bit up);
      if (up) return (c == 3) ? 3 : c + 1;
      return (c == 0) ? 0 : c - 1;
   endfunction

   function automatic int unsigned idx7(input logic [31:0] pc);
      return (pc >> 2) % 128;
   endfunction

   function automatic int unsigned gidx(input logic [31:0] pc);
      return ((pc >> 2) % 256) ^ m_ghr;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 128; i++) begin
         m_btb[i]  = 0;
         m_lht[i]  = 0;
         m_meta[i] = 1;
      end
      for (int i = 0; i < 256; i++) begin
         m_lpht[i] = 1;
         m_gpht[i] = 1;
      end
      m_ghr = 0;
   endtask

   // Applies the edge using the inputs held during the cycle just ended.
   task automatic model_edge();
      int unsigned ix, lh, gi;
      bit l, g;
      if (!rst) begin
         model_reset();
      end else if (is_branch_ex) begin
         ix = idx7(pc_ex);
         lh = m_lht[ix];
         gi = gidx(pc_ex);
         l  = m_lpht[lh] >= 2;
         g  = m_gpht[gi] >= 2;
         m_btb[ix]  = branch_pc_ex;
         m_lpht[lh] = sat(m_lpht[lh], br_en_ex);
         m_gpht[gi] = sat(m_gpht[gi], br_en_ex);
         if (l != g) m_meta[ix] = sat(m_meta[ix], g == br_en_ex);
         m_lht[ix] = ((lh << 1) | 32'(br_en_ex)) % 256;
         m_ghr     = ((m_ghr << 1) | 32'(br_en_ex)) % 256;
      end
   endtask

   task automatic compare_outputs();
      int unsigned ix;
      bit l, g, ug;
      ix = idx7(pc_if);
      l  = m_lpht[m_lht[ix]] >= 2;
      g  = m_gpht[gidx(pc_if)] >= 2;
      ug = m_meta[ix] >= 2;
      chk("predicted_pc", predicted_pc, m_btb[ix]);
      chk("local_taken", 32'(local_taken), 32'(l));
      chk("global_taken", 32'(global_taken), 32'(g));
      chk("use_global", 32'(use_global), 32'(ug));
      chk("predict_taken", 32'(predict_taken), 32'(is_branch_if && (ug ? g : l)));
   endtask

   task automatic at_sample();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic r, input logic [31:0] pif, input logic bif,
                        input logic [31:0] pex, input logic bex, input logic ten,
                        input logic [31:0] tgt);
      rst          = r;
      pc_if        = pif;
      is_branch_if = bif;
      pc_ex        = pex;
      is_branch_ex = bex;
      br_en_ex     = ten;
      branch_pc_ex = tgt;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) p = p | 32'h1000_0000;
      return p;
   endfunction

   initial begin
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
      model_reset();
      repeat (2) finish_cycle();

      // Reset state.
      drive(1'b1, 32'h40, 1'b1, '0, 1'b0, 1'b0, '0);
      at_sample();
      chk("rst_predicted_pc", predicted_pc, 32'h0);
      chk("rst_predict_taken", 32'(predict_taken), 32'h0);
      chk("rst_use_global", 32'(use_global), 32'h0);
      finish_cycle();

      // BTB write: old value in write cycle, new value next cycle.
      drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100);
      at_sample();
      chk("btb_same_cycle", predicted_pc, 32'h0);
      finish_cycle();
      drive(1'b1, 32'h40, 1'b1, '0, 1'b0, 1'b0, '0);
      at_sample();
      chk("btb_next_cycle", predicted_pc, 32'h100);
      finish_cycle();

      // Aliasing through shared index 0x10.
      drive(1'b1, 32'h40, 1'b0, 32'h240, 1'b1, 1'b0, 32'h500);
      at_sample();
      finish_cycle();
      drive(1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0, '0);
      at_sample();
      chk("btb_alias", predicted_pc, 32'h500);
      finish_cycle();

      // Reset concurrent with an update wins.
      drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h777);
      finish_cycle();
      drive(1'b1, 32'h40, 1'b1, '0, 1'b0, 1'b0, '0);
      at_sample();
      chk("rst_over_update_pc", predicted_pc, 32'h0);
      chk("rst_over_update_pt", 32'(predict_taken), 32'h0);
      finish_cycle();

      // Alternating T/N at 0x80 from clean state, 20 resolutions.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, (i % 2) == 0, 32'h200);
         at_sample();
         finish_cycle();
      end
      drive(1'b1, 32'h80, 1'b1, '0, 1'b0, 1'b0, '0);
      at_sample();
      chk("alt_local_taken", 32'(local_taken), 32'h1);
      chk("alt_global_taken", 32'(global_taken), 32'h1);
      chk("alt_use_global", 32'(use_global), 32'h0);
      chk("alt_predict_taken", 32'(predict_taken), 32'h1);
      chk("alt_predicted_pc", predicted_pc, 32'h200);
      finish_cycle();

      // Randomized traffic; outputs checked against the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pex, pif;
         pex = rand_pc();
         pif = ($urandom_range(0, 2) == 0) ? pex : rand_pc();
         drive(($urandom_range(0, 299) != 0), pif, 1'($urandom_range(0, 1)), pex,
               ($urandom_range(0, 3) != 0),
               (pex[4] ^ ($urandom_range(0, 4) == 0)),
               $urandom());
         at_sample();
         finish_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
